// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter feeding one ECC FIFO write port,
// with a mid-packet stall watchdog that forcibly releases a silent owner.
module fifo_wr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int WDOG_CYCLES = 16
) (
    input  logic                          Clock,
    input  logic                          Reset_,
    input  logic [NUM_REQ-1:0]            Req_Valid,
    input  logic [NUM_REQ-1:0]            Req_Last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data,
    output logic [NUM_REQ-1:0]            Req_Ready,
    input  logic                          Fifo_Full_,
    output logic                          Fifo_WriteEn,
    output logic [DATA_WIDTH-1:0]         Fifo_DataIn,
    output logic [NUM_REQ-1:0]            Grant,
    output logic                          Abort,
    output logic                          Pkt_Done
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WW = $clog2(WDOG_CYCLES) + 1;
    localparam logic [WW-1:0] WD_MAX   = WW'(WDOG_CYCLES - 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t               state_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [PW-1:0]        ptr_q;
    logic [WW-1:0]        wd_q;
    logic                 abort_q;
    logic                 done_q;

    logic [NUM_REQ-1:0]   own_valid;
    logic                 beat;
    logic                 last;
    logic                 stall;
    logic                 wd_hit;
    logic [PW-1:0]        owner;
    logic [PW-1:0]        owner_inc;
    logic [NUM_REQ-1:0]   idle_pick;
    logic [NUM_REQ-1:0]   rel_pick;
    logic [DATA_WIDTH-1:0] data_mux;

    // First set bit at or above start, wrapping modulo NUM_REQ.
    function automatic logic [NUM_REQ-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [PW-1:0]      start
    );
        logic [NUM_REQ-1:0] g;
        logic               found;
        int                 idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(start) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    assign own_valid = grant_q & Req_Valid;
    assign beat      = (|own_valid) & Fifo_Full_;
    assign last      = beat & (|(grant_q & Req_Last));
    assign stall     = (state_q == OWNED) & ~(|own_valid) & Fifo_Full_;
    assign wd_hit    = stall & (wd_q == WD_MAX);

    always_comb begin
        owner    = '0;
        data_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner    = PW'(i);
                data_mux = data_mux | Req_Data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign owner_inc = (owner == LAST_IDX) ? '0 : owner + PW'(1);
    assign idle_pick = rr_pick(Req_Valid, ptr_q);
    // The releasing owner's valid bit is the beat it just sent, not a new request.
    assign rel_pick  = rr_pick(Req_Valid & ~grant_q, owner_inc);

    always_ff @(posedge Clock or negedge Reset_) begin
        if (!Reset_) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            wd_q    <= '0;
            abort_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            abort_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    wd_q <= '0;
                    if (|Req_Valid) begin
                        grant_q <= idle_pick;
                        state_q <= OWNED;
                    end
                end
                OWNED: begin
                    if (last) begin
                        ptr_q   <= owner_inc;
                        done_q  <= 1'b1;
                        grant_q <= rel_pick;
                        state_q <= (|rel_pick) ? OWNED : IDLE;
                        wd_q    <= '0;
                    end else if (wd_hit) begin
                        ptr_q   <= owner_inc;
                        abort_q <= 1'b1;
                        grant_q <= '0;
                        state_q <= IDLE;
                        wd_q    <= '0;
                    end else if (beat) begin
                        wd_q <= '0;
                    end else if (stall) begin
                        wd_q <= wd_q + WW'(1);
                    end
                end
            endcase
        end
    end

    assign Grant        = grant_q;
    assign Req_Ready    = grant_q & {NUM_REQ{Fifo_Full_}};
    assign Fifo_WriteEn = beat;
    assign Fifo_DataIn  = data_mux;
    assign Abort        = abort_q;
    assign Pkt_Done     = done_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: ownership, round robin, backpressure,
// packet lock, watchdog release and asynchronous reset.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;

    logic            Clock;
    logic            Reset_;
    logic [N-1:0]    Req_Valid;
    logic [N-1:0]    Req_Last;
    logic [N*DW-1:0] Req_Data;
    logic [N-1:0]    Req_Ready;
    logic            Fifo_Full_;
    logic            Fifo_WriteEn;
    logic [DW-1:0]   Fifo_DataIn;
    logic [N-1:0]    Grant;
    logic            Abort;
    logic            Pkt_Done;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] dv [N];

    fifo_wr_arbiter #(
        .NUM_REQ(N),
        .DATA_WIDTH(DW),
        .WDOG_CYCLES(16)
    ) dut (
        .Clock(Clock),
        .Reset_(Reset_),
        .Req_Valid(Req_Valid),
        .Req_Last(Req_Last),
        .Req_Data(Req_Data),
        .Req_Ready(Req_Ready),
        .Fifo_Full_(Fifo_Full_),
        .Fifo_WriteEn(Fifo_WriteEn),
        .Fifo_DataIn(Fifo_DataIn),
        .Grant(Grant),
        .Abort(Abort),
        .Pkt_Done(Pkt_Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic tick;
        @(posedge Clock);
        #1;
    endtask

    task automatic load_data;
        for (int i = 0; i < N; i++) begin
            dv[i] = {32'hD00D_0000, 32'(i + 1)} ^ (64'h1111 << (i * 8));
            Req_Data[i*DW +: DW] = dv[i];
        end
    endtask

    task automatic do_reset;
        Reset_     = 1'b0;
        Req_Valid  = '0;
        Req_Last   = '0;
        Fifo_Full_ = 1'b1;
        load_data();
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset_ = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        checks++;
        if (Grant !== 4'b0000) begin
            errors++;
            $display("FAIL reset_grant: got %b want 0000", Grant);
        end
        checks++;
        if (Fifo_WriteEn !== 1'b0 || Req_Ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_we_ready: got we=%b rdy=%b want 0/0000",
                     Fifo_WriteEn, Req_Ready);
        end
        checks++;
        if (Abort !== 1'b0 || Pkt_Done !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: got abort=%b done=%b want 0/0",
                     Abort, Pkt_Done);
        end
        checks++;
        if (Fifo_DataIn !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", Fifo_DataIn);
        end
    endtask

    task automatic test_single_owner;
        do_reset();
        Req_Valid = 4'b0001;
        Req_Last  = 4'b0000;
        #1;
        checks++;
        if (Grant !== 4'b0000 || Fifo_WriteEn !== 1'b0) begin
            errors++;
            $display("FAIL single_c0: got grant=%b we=%b want 0000/0",
                     Grant, Fifo_WriteEn);
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            Req_Last = (c == 3) ? 4'b0001 : 4'b0000;
            #1;
            checks++;
            if (Grant !== 4'b0001 || Fifo_WriteEn !== 1'b1 ||
                Fifo_DataIn !== dv[0]) begin
                errors++;
                $display("FAIL single_beat%0d: got grant=%b we=%b data=%h want 0001/1/%h",
                         c, Grant, Fifo_WriteEn, Fifo_DataIn, dv[0]);
            end
        end
        tick();
        Req_Valid = 4'b0000;
        Req_Last  = 4'b0000;
        #1;
        checks++;
        if (Pkt_Done !== 1'b1 || Grant !== 4'b0000 || Fifo_WriteEn !== 1'b0) begin
            errors++;
            $display("FAIL single_done: got done=%b grant=%b we=%b want 1/0000/0",
                     Pkt_Done, Grant, Fifo_WriteEn);
        end
        tick();
        #1;
        checks++;
        if (Pkt_Done !== 1'b0) begin
            errors++;
            $display("FAIL single_done_pulse: got done=%b want 0", Pkt_Done);
        end
    endtask

    task automatic test_round_robin;
        logic [N-1:0] exp_g;
        int           w;
        do_reset();
        Req_Valid = 4'b1111;
        Req_Last  = 4'b1111;
        for (int k = 1; k <= 5; k++) begin
            tick();
            #1;
            w     = (k - 1) % N;
            exp_g = 4'b0001 << w;
            checks++;
            if (Grant !== exp_g || Fifo_WriteEn !== 1'b1 ||
                Fifo_DataIn !== dv[w]) begin
                errors++;
                $display("FAIL rr_cycle%0d: got grant=%b we=%b data=%h want %b/1/%h",
                         k, Grant, Fifo_WriteEn, Fifo_DataIn, exp_g, dv[w]);
            end
            if (k >= 2) begin
                checks++;
                if (Pkt_Done !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_done%0d: got %b want 1", k, Pkt_Done);
                end
            end
        end
        Req_Valid = 4'b0000;
        Req_Last  = 4'b0000;
    endtask

    task automatic test_backpressure;
        do_reset();
        Req_Valid = 4'b0001;
        Req_Last  = 4'b0000;
        tick();
        #1;
        checks++;
        if (Fifo_WriteEn !== 1'b1) begin
            errors++;
            $display("FAIL bp_first: got we=%b want 1", Fifo_WriteEn);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            Fifo_Full_ = 1'b0;
            #1;
            checks++;
            if (Fifo_WriteEn !== 1'b0 || Req_Ready !== 4'b0000 ||
                Grant !== 4'b0001) begin
                errors++;
                $display("FAIL bp_full%0d: got we=%b rdy=%b grant=%b want 0/0000/0001",
                         c, Fifo_WriteEn, Req_Ready, Grant);
            end
        end
        tick();
        Fifo_Full_ = 1'b1;
        Req_Last   = 4'b0001;
        #1;
        checks++;
        if (Fifo_WriteEn !== 1'b1 || Req_Ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_resume: got we=%b rdy=%b want 1/0001",
                     Fifo_WriteEn, Req_Ready);
        end
        tick();
        Req_Valid = 4'b0000;
        Req_Last  = 4'b0000;
        #1;
        checks++;
        if (Pkt_Done !== 1'b1 || Grant !== 4'b0000) begin
            errors++;
            $display("FAIL bp_done: got done=%b grant=%b want 1/0000",
                     Pkt_Done, Grant);
        end
    endtask

    task automatic test_lock;
        do_reset();
        Req_Valid = 4'b0010;
        Req_Last  = 4'b0000;
        for (int c = 1; c <= 4; c++) begin
            tick();
            Req_Valid = 4'b0011;
            Req_Last  = (c == 4) ? 4'b0011 : 4'b0001;
            #1;
            checks++;
            if (Grant !== 4'b0010 || Req_Ready[0] !== 1'b0 ||
                Fifo_DataIn !== dv[1] || Fifo_WriteEn !== 1'b1) begin
                errors++;
                $display("FAIL lock_beat%0d: got grant=%b rdy=%b data=%h want 0010/xx0x/%h",
                         c, Grant, Req_Ready, Fifo_DataIn, dv[1]);
            end
        end
        tick();
        Req_Valid = 4'b0001;
        Req_Last  = 4'b0001;
        #1;
        checks++;
        if (Grant !== 4'b0001 || Pkt_Done !== 1'b1 ||
            Fifo_WriteEn !== 1'b1 || Fifo_DataIn !== dv[0]) begin
            errors++;
            $display("FAIL lock_handoff: got grant=%b done=%b we=%b data=%h want 0001/1/1/%h",
                     Grant, Pkt_Done, Fifo_WriteEn, Fifo_DataIn, dv[0]);
        end
        tick();
        Req_Valid = 4'b0000;
        Req_Last  = 4'b0000;
    endtask

    task automatic test_watchdog;
        int stalls;
        do_reset();
        Req_Valid = 4'b0100;
        Req_Last  = 4'b0000;
        tick();
        #1;
        checks++;
        if (Grant !== 4'b0100 || Fifo_WriteEn !== 1'b1) begin
            errors++;
            $display("FAIL wd_grant: got grant=%b we=%b want 0100/1",
                     Grant, Fifo_WriteEn);
        end
        stalls = 0;
        for (int c = 0; c < 26; c++) begin
            tick();
            Req_Valid  = 4'b0000;
            Fifo_Full_ = (c >= 10 && c < 20) ? 1'b0 : 1'b1;
            if (Fifo_Full_) stalls++;
            #1;
            checks++;
            if (Abort !== 1'b0 || Grant !== 4'b0100) begin
                errors++;
                $display("FAIL wd_hold%0d: got abort=%b grant=%b want 0/0100",
                         c, Abort, Grant);
            end
        end
        checks++;
        if (stalls != 16) begin
            errors++;
            $display("FAIL wd_stall_count: got %0d want 16", stalls);
        end
        tick();
        Req_Valid = 4'b1001;
        #1;
        checks++;
        if (Abort !== 1'b1 || Grant !== 4'b0000 || Pkt_Done !== 1'b0) begin
            errors++;
            $display("FAIL wd_abort: got abort=%b grant=%b done=%b want 1/0000/0",
                     Abort, Grant, Pkt_Done);
        end
        tick();
        #1;
        checks++;
        if (Abort !== 1'b0 || Grant !== 4'b1000) begin
            errors++;
            $display("FAIL wd_next: got abort=%b grant=%b want 0/1000",
                     Abort, Grant);
        end
        Req_Valid = 4'b0000;
    endtask

    task automatic test_reset_mid_packet;
        do_reset();
        Req_Valid = 4'b0001;
        Req_Last  = 4'b0000;
        tick();
        tick();
        #1;
        checks++;
        if (Fifo_WriteEn !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: got we=%b want 1", Fifo_WriteEn);
        end
        Reset_ = 1'b0;
        #1;
        checks++;
        if (Grant !== 4'b0000 || Fifo_WriteEn !== 1'b0 ||
            Req_Ready !== 4'b0000 || Fifo_DataIn !== 64'h0 ||
            Abort !== 1'b0 || Pkt_Done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got grant=%b we=%b rdy=%b data=%h abort=%b done=%b want all 0",
                     Grant, Fifo_WriteEn, Req_Ready, Fifo_DataIn, Abort, Pkt_Done);
        end
        Req_Valid = 4'b0110;
        @(posedge Clock);
        @(negedge Clock);
        Reset_ = 1'b1;
        tick();
        #1;
        checks++;
        if (Grant !== 4'b0010 || Pkt_Done !== 1'b0 || Abort !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_regrant: got grant=%b done=%b abort=%b want 0010/0/0",
                     Grant, Pkt_Done, Abort);
        end
        Req_Valid = 4'b0000;
    endtask

    initial begin
        Reset_     = 1'b0;
        Req_Valid  = '0;
        Req_Last   = '0;
        Req_Data   = '0;
        Fifo_Full_ = 1'b1;
        test_reset();
        test_single_owner();
        test_round_robin();
        test_backpressure();
        test_lock();
        test_watchdog();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
